// File: rtl/rc4_decrypt_check.sv
// RC4 keystream decrypt stage: decrypts MSG_LEN ciphertext bytes and checks that every
// plaintext byte is 'a'..'z' or space. Define EARLY_ABORT_EN to stop at the first invalid byte.
module rc4_decrypt_check #(
  parameter int MSG_LEN = 32,
  parameter int D_AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            finish,
  output logic            key_found,
  output logic [7:0]      s_addr,
  output logic [7:0]      s_wdata,
  output logic            s_wren,
  input  logic [7:0]      s_rdata,
  output logic [D_AW-1:0] rom_addr,
  input  logic [7:0]      rom_rdata,
  output logic [D_AW-1:0] d_addr,
  output logic [7:0]      d_wdata,
  output logic            d_wren
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] INC_I    = 4'd1;
  localparam logic [3:0] WAIT_SI  = 4'd2;
  localparam logic [3:0] READ_SI  = 4'd3;
  localparam logic [3:0] WAIT_SJ  = 4'd4;
  localparam logic [3:0] READ_SJ  = 4'd5;
  localparam logic [3:0] WRITE_SI = 4'd6;
  localparam logic [3:0] WRITE_SJ = 4'd7;
  localparam logic [3:0] READ_F   = 4'd8;
  localparam logic [3:0] WAIT_F   = 4'd9;
  localparam logic [3:0] COMPUTE  = 4'd10;
  localparam logic [3:0] WRITE_D  = 4'd11;
  localparam logic [3:0] DONE     = 4'd12;

  localparam logic [D_AW-1:0] K_ONE  = D_AW'(1);
  localparam logic [D_AW-1:0] K_LAST = D_AW'(MSG_LEN - 1);

  logic [3:0]      r_state;
  logic [7:0]      r_i, r_j, r_si, r_sj, r_p;
  logic [D_AW-1:0] r_k;
  logic            r_bad, r_finish, r_key_found;
  logic [7:0]      r_s_addr, r_s_wdata;
  logic            r_s_wren, r_d_wren;
  logic [D_AW-1:0] r_rom_addr, r_d_addr;
  logic [7:0]      r_d_wdata;

  logic [7:0] w_j_next;
  logic       w_p_valid, w_bad_next, w_stop;

  assign w_j_next   = r_j + s_rdata;
  assign w_p_valid  = ((r_p >= 8'h61) && (r_p <= 8'h7A)) || (r_p == 8'h20);
  assign w_bad_next = r_bad | ~w_p_valid;
`ifdef EARLY_ABORT_EN
  assign w_stop     = (r_k == K_LAST) || w_bad_next;
`else
  assign w_stop     = (r_k == K_LAST);
`endif

  // Read addresses are registered by the state that issues them, so data returns two
  // states later; write strobes are registered on entry so they coincide with the WRITE_* state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_p         <= '0;
      r_bad       <= 1'b0;
      r_finish    <= 1'b0;
      r_key_found <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wren    <= 1'b0;
      r_rom_addr  <= '0;
      r_d_addr    <= '0;
      r_d_wdata   <= '0;
      r_d_wren    <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere; these defaults make strobes single-state pulses.
      r_s_wren <= 1'b0;
      r_d_wren <= 1'b0;
      r_finish <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state     <= INC_I;
          r_i         <= '0;
          r_j         <= '0;
          r_k         <= '0;
          r_bad       <= 1'b0;
          r_key_found <= 1'b0;
        end
        INC_I: begin
          r_i      <= r_i + 8'd1;
          r_s_addr <= r_i + 8'd1;
          r_state  <= WAIT_SI;
        end
        WAIT_SI: r_state <= READ_SI;
        READ_SI: begin
          r_si     <= s_rdata;
          r_j      <= w_j_next;
          r_s_addr <= w_j_next;
          r_state  <= WAIT_SJ;
        end
        WAIT_SJ: r_state <= READ_SJ;
        READ_SJ: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_i;
          r_s_wdata <= s_rdata;
          r_s_wren  <= 1'b1;
          r_state   <= WRITE_SI;
        end
        WRITE_SI: begin
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_s_wren  <= 1'b1;
          r_state   <= WRITE_SJ;
        end
        WRITE_SJ: r_state <= READ_F;
        READ_F: begin
          r_s_addr   <= r_si + r_sj;
          r_rom_addr <= r_k;
          r_state    <= WAIT_F;
        end
        WAIT_F: r_state <= COMPUTE;
        COMPUTE: begin
          r_p       <= s_rdata ^ rom_rdata;
          r_d_addr  <= r_k;
          r_d_wdata <= s_rdata ^ rom_rdata;
          r_d_wren  <= 1'b1;
          r_state   <= WRITE_D;
        end
        WRITE_D: begin
          r_bad <= w_bad_next;
          if (w_stop) begin
            r_finish    <= 1'b1;
            r_key_found <= ~w_bad_next;
            r_state     <= DONE;
          end else begin
            r_k     <= r_k + K_ONE;
            r_state <= INC_I;
          end
        end
        DONE: if (!start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign finish    = r_finish;
  assign key_found = r_key_found;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wren    = r_s_wren;
  assign rom_addr  = r_rom_addr;
  assign d_addr    = r_d_addr;
  assign d_wdata   = r_d_wdata;
  assign d_wren    = r_d_wren;

endmodule

// File: tb/tb_rc4_decrypt_check.sv
// Randomized bench for rc4_decrypt_check: RC4 PRGA reference model, bench-side S RAM, ROM and
// result RAM. Honors EARLY_ABORT_EN in its expectations.
module tb_rc4_decrypt_check;
  localparam int MSG_LEN = 32;
  localparam int D_AW    = 5;

  logic            clk = 1'b0;
  logic            reset, start;
  logic            finish, key_found, s_wren, d_wren;
  logic [7:0]      s_addr, s_wdata, s_rdata, rom_rdata, d_wdata;
  logic [D_AW-1:0] rom_addr, d_addr;

  always #5 clk = ~clk;

  rc4_decrypt_check #(.MSG_LEN(MSG_LEN), .D_AW(D_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .key_found(key_found),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren)
  );

  logic [7:0] s_mem [256];
  logic [7:0] s_init[256];
  logic [7:0] s_fin [256];
  logic [7:0] rom   [MSG_LEN];
  logic [7:0] d_mem [MSG_LEN];
  logic [7:0] pt    [MSG_LEN];
  logic [7:0] ks    [MSG_LEN];
  logic       load_s = 1'b0;
  int s_wr_cnt = 0, d_wr_cnt = 0, fin_cnt = 0;
  int n_checks = 0, n_fail = 0;
  int exp_n;
  logic exp_kf;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    s_rdata   <= s_mem[s_addr];
    rom_rdata <= rom[rom_addr];
    if (load_s) s_mem <= s_init;
    else if (s_wren) s_mem[s_addr] <= s_wdata;
    if (s_wren) s_wr_cnt++;
    if (d_wren) begin
      d_mem[d_addr] <= d_wdata;
      d_wr_cnt++;
    end
    if (finish) fin_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, {8'h0, s_addr, s_wdata, d_wdata}, 32'h0);
    check({tag, "_ctrl"}, {18'h0, rom_addr, d_addr, finish, key_found, s_wren, d_wren}, 32'h0);
  endtask

  function automatic logic is_valid(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  function automatic logic [7:0] rand_valid();
    int r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_invalid();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_valid(b));
    return b;
  endfunction

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic set_perm();
    logic [7:0] t;
    int r;
    set_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(0, x);
      t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic fill_valid();
    for (int k = 0; k < MSG_LEN; k++) pt[k] = rand_valid();
  endtask

  // Reference: plain RC4 PRGA over s_init; ROM = plaintext XOR keystream.
  task automatic prepare();
    logic [7:0] s[256];
    logic [7:0] i, j, t;
    logic seen_bad;
    exp_n = MSG_LEN; exp_kf = 1'b1; seen_bad = 1'b0;
    for (int k = 0; k < MSG_LEN; k++) if (!is_valid(pt[k])) begin
      exp_kf = 1'b0;
`ifdef EARLY_ABORT_EN
      if (!seen_bad) exp_n = k + 1;
`endif
      seen_bad = 1'b1;
    end
    for (int x = 0; x < 256; x++) s[x] = s_init[x];
    i = 0; j = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[k]  = s[8'(s[i] + s[j])];
      rom[k] = pt[k] ^ ks[k];
      if (k + 1 == exp_n) for (int x = 0; x < 256; x++) s_fin[x] = s[x];
    end
    @(negedge clk) load_s = 1'b1;
    @(negedge clk) load_s = 1'b0;
  endtask

  task automatic run_check(input string tag, input int hold);
    int s0, d0, f0, cyc, errs;
    logic got;
    s0 = s_wr_cnt; d0 = d_wr_cnt; f0 = fin_cnt; cyc = 0; got = 1'b0;
    @(negedge clk) start = 1'b1;
    while (cyc < 2000 && !got) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) check({tag, "_kf_clr"}, key_found, 1'b0);
      if (finish) got = 1'b1;
    end
    check({tag, "_fin_cyc"}, cyc, 11 * exp_n + 1);
    check({tag, "_key_found"}, key_found, exp_kf);
    check({tag, "_d_writes"}, d_wr_cnt - d0, exp_n);
    check({tag, "_s_writes"}, s_wr_cnt - s0, 2 * exp_n);
    check({tag, "_d0"}, d_mem[0], pt[0]);
    errs = 0;
    for (int k = 0; k < exp_n; k++) if (d_mem[k] !== pt[k]) errs++;
    check({tag, "_d_bytes"}, errs, 0);
    errs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== s_fin[x]) errs++;
    check({tag, "_s_final"}, errs, 0);
    repeat (hold) @(posedge clk);
    #1 check({tag, "_fin_pulses"}, fin_cnt - f0, 1);
    check({tag, "_no_retrig"}, d_wr_cnt - d0, exp_n);
    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check({tag, "_kf_hold"}, key_found, exp_kf);
  endtask

  initial begin
    logic [7:0] bnd[4];
    int s0, d0, f0, k;
    reset = 1'b1; start = 1'b0;
    for (int x = 0; x < MSG_LEN; x++) begin rom[x] = 8'h0; d_mem[x] = 8'h0; end
    set_identity();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Identity S, all-valid message, first plaintext 'a' (ROM[0] = 8'h63).
    set_identity(); fill_valid(); pt[0] = 8'h61; prepare();
    run_check("ident", 1);

    // Invalid byte at k=5.
    set_identity(); fill_valid(); pt[5] = rand_invalid(); prepare();
    run_check("bad5", 1);

    // Validity boundaries, each as the only candidate bad byte.
    bnd[0] = 8'h20; bnd[1] = 8'h7A; bnd[2] = 8'h60; bnd[3] = 8'h7B;
    for (int b = 0; b < 4; b++) begin
      set_perm(); fill_valid(); pt[$urandom_range(0, MSG_LEN - 1)] = bnd[b]; prepare();
      run_check($sformatf("bnd_%02h", bnd[b]), 1);
    end

    // Random permutations with sparse invalid bytes.
    for (int r = 0; r < 3; r++) begin
      set_perm();
      for (int x = 0; x < MSG_LEN; x++)
        pt[x] = ($urandom_range(0, 15) == 0) ? rand_invalid() : rand_valid();
      prepare();
      run_check($sformatf("rand%0d", r), 1);
    end

    // Reset in the middle of byte 3, then a fresh full run.
    set_identity(); fill_valid(); pt[0] = 8'h61; prepare();
    @(negedge clk) start = 1'b1;
    k = 34 + $urandom_range(0, 10);
    repeat (k) @(posedge clk);
    #2 reset = 1'b1; start = 1'b0;
    #1 check_zero("midrst");
    s0 = s_wr_cnt; d0 = d_wr_cnt; f0 = fin_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("midrst_no_wr", (s_wr_cnt - s0) + (d_wr_cnt - d0) + (fin_cnt - f0), 0);
    prepare();
    run_check("after_rst", 1);

    // Start held 20 cycles past finish, then a restart that must clear key_found.
    set_perm(); fill_valid(); prepare();
    run_check("hold20", 20);
    set_perm(); fill_valid(); prepare();
    run_check("restart", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rc4_decrypt_check.md
RC4_DECRYPT_CHECK -- requirements
Module: rc4_decrypt_check

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, meaning the number of ciphertext bytes to decrypt and check.
REQ-002 SHALL have parameter D_AW, default 5, meaning the address width of the ciphertext ROM and of the result RAM.
REQ-003 SHALL have a single clock and a single reset: reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the system clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level request from the controller to begin the decrypt stage.
REQ-007 SHALL have port finish, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port key_found, output, 1 bit: 1 when every checked plaintext byte was valid.
REQ-009 SHALL have ports s_addr (output, 8 bits), s_wdata (output, 8 bits), s_wren (output, 1 bit) and s_rdata (input, 8 bits): the S-array RAM port.
REQ-010 SHALL have ports rom_addr (output, D_AW bits) and rom_rdata (input, 8 bits): the ciphertext ROM port.
REQ-011 SHALL have ports d_addr (output, D_AW bits), d_wdata (output, 8 bits) and d_wren (output, 1 bit): the result RAM port.

Function
REQ-012 SHALL treat both RAM reads and ROM reads as synchronous, with data valid exactly 1 cycle after the address is presented.
REQ-013 SHALL implement the states IDLE, INC_I, WAIT_SI, READ_SI, WAIT_SJ, READ_SJ, WRITE_SI, WRITE_SJ, READ_F, WAIT_F, COMPUTE, WRITE_D and DONE, each lasting 1 cycle except IDLE and DONE.
REQ-014 SHALL move IDLE->INC_I when start=1, and on that transition clear i, j, the byte index k, and key_found to 0.
REQ-015 SHALL, in INC_I, set i=i+1 (mod 256) and s_addr=i+1.
REQ-016 SHALL, in READ_SI, latch si=s_rdata, set j=j+si (mod 256), and set s_addr to the new j.
REQ-017 SHALL, in READ_SJ, latch sj=s_rdata.
REQ-018 SHALL, in WRITE_SI, drive s_addr=i, s_wdata=sj, s_wren=1.
REQ-019 SHALL, in WRITE_SJ, drive s_addr=j, s_wdata=si, s_wren=1.
REQ-020 SHALL, in READ_F, drive s_addr=(si+sj) mod 256 and rom_addr=k.
REQ-021 SHALL, in COMPUTE, form the plaintext byte p = s_rdata XOR rom_rdata and register it.
REQ-022 SHALL, in WRITE_D, drive d_addr=k, d_wdata=p, d_wren=1.
REQ-023 SHALL treat p as valid iff 8'h61<=p<=8'h7A or p=8'h20; an invalid p SHALL set an internal sticky bad flag.
REQ-024 SHALL go from WRITE_D to DONE if k=MSG_LEN-1 or abort applies (REQ-033); otherwise it SHALL set k=k+1 and go to INC_I.
REQ-025 SHALL give a per-byte latency of exactly 11 cycles, so finish is high 11*n+1 cycles after start is sampled, where n is the number of bytes processed.
REQ-026 SHALL, on DONE entry, pulse finish=1 for exactly 1 cycle and set key_found=!bad.
REQ-027 SHALL hold key_found until the next IDLE->INC_I transition.
REQ-028 SHALL stay in DONE while start=1 and return to IDLE only after start=0; start held high SHALL NOT retrigger the stage.
REQ-029 SHALL keep s_wren and d_wren at 0 in every state not named above as writing.
REQ-030 SHALL ignore changes on start while busy.

Reset
REQ-031 SHALL, while reset=1 (at any time, including mid-byte), immediately force: state IDLE; i, j, k, si, sj, p and bad to 0; finish, key_found, s_wren and d_wren to 0; and all address and data outputs to 0.
REQ-032 SHALL, after reset is released, perform no RAM writes until a new start is seen.

Configuration
REQ-033 SHALL, when EARLY_ABORT_EN is defined, go from WRITE_D to DONE as soon as bad=1, writing the offending byte first; when it is undefined, all MSG_LEN bytes SHALL always be processed, with key_found = no byte invalid.

Verification
REQ-034 SHALL cover: S[x]=x, ROM[0]=8'h63, ROM chosen so every byte decrypts to 'a'..'z' -> d[0]=8'h61, finish at cycle 353, key_found=1.
REQ-035 SHALL cover (EARLY_ABORT_EN): ROM[0] decrypting to 8'h60 -> finish at cycle 12, key_found=0, exactly one d_wren pulse at d_addr=0.
REQ-036 SHALL cover (no macro): invalid byte at k=5 -> 32 d_wren pulses, finish at cycle 353, key_found=0.
REQ-037 SHALL cover boundaries: plaintext 8'h20 and 8'h7A accepted, 8'h60 and 8'h7B rejected, each as a single-bad-byte message.
REQ-038 SHALL cover: reset asserted during byte 3 -> outputs zero in the same cycle, no further writes; a fresh start then gives the full-run result of REQ-034.
REQ-039 SHALL cover: start held high for 20 cycles after finish -> single finish pulse, no restart; start low then high -> new run, with key_found cleared at restart.
